// File: rtl/ahbarbiter.sv
// Round-robin AHB arbiter: registered one-hot grant, data-phase owner tracking
// and a beat limit. Define AHBARB_LOCK_EN to honour HMASTLOCK.

module priorityencoder #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);
    // Lowest set bit wins; with a one-hot input this is a plain encoder.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

module ahbarbiter #(
    parameter int N        = 3,
    parameter int MAXBEATS = 16,
    localparam int IW      = $clog2(N),
    localparam int CW      = $clog2(MAXBEATS) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  Req,
    input  logic [N-1:0]  Lock,
    input  logic          HREADY,
    output logic [N-1:0]  Grant,
    output logic [IW-1:0] GrantIdx,
    output logic          GrantValid,
    output logic [IW-1:0] DataIdx,
    output logic          DataValid
);
    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   lastidx_q, lastidx_d;
    logic [CW-1:0]   beatcnt_q, beatcnt_d;
    logic [IW-1:0]   didx_p1;
    logic            dvld_p1;

    logic            pevalid;
    logic            ownerreq;
    logic            accepted;
    logic            others;
    logic            atlimit;
    logic            limitpre;
    logic            locked;
    logic            arb;
    logic            winvalid;
    logic [IW-1:0]   winidx;
    logic [IW-1:0]   cand;

    priorityencoder #(.N(N)) pe (
        .vec   (grant_q),
        .idx   (GrantIdx),
        .valid (pevalid)
    );

    assign Grant      = grant_q;
    assign GrantValid = pevalid;
    assign DataIdx    = didx_p1;
    assign DataValid  = dvld_p1;

    assign ownerreq = GrantValid & Req[GrantIdx];
    assign accepted = HREADY & ownerreq;
    assign others   = |(Req & ~grant_q);
    assign atlimit  = (beatcnt_q >= CW'(MAXBEATS - 1));

`ifdef AHBARB_LOCK_EN
    assign locked = GrantValid & Lock[GrantIdx];
`else
    logic unused_lock;
    assign unused_lock = ^Lock;
    assign locked      = 1'b0;
`endif

    // A locked owner keeps the bus through idle cycles and past the beat limit.
    assign limitpre = atlimit & accepted & others & ~locked;
    assign arb = HREADY & (((state_q == IDLE) & (|Req)) |
                           ((state_q == OWNED) & ~ownerreq & ~locked) |
                           limitpre);

    // Scan from LastIdx+1 with wrap; offset N lands on the owner, so it comes last.
    always_comb begin
        winvalid = 1'b0;
        winidx   = '0;
        cand     = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(lastidx_q) + k) % N);
            if (Req[cand] && !(limitpre && (cand == GrantIdx))) begin
                winvalid = 1'b1;
                winidx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        lastidx_d = lastidx_q;
        beatcnt_d = beatcnt_q;
        if (arb) begin
            beatcnt_d = '0;
            if (winvalid) begin
                state_d         = OWNED;
                grant_d         = '0;
                grant_d[winidx] = 1'b1;
                lastidx_d       = winidx;
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end else if (accepted) begin
            // Counter saturates while locked so release rotates straight away.
            if (atlimit && !others) begin
                beatcnt_d = '0;
            end else if (beatcnt_q != '1) begin
                beatcnt_d = beatcnt_q + CW'(1);
            end
        end
    end

    // Address phase -> data phase boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            lastidx_q <= IW'(N - 1);
            beatcnt_q <= '0;
            didx_p1   <= '0;
            dvld_p1   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            lastidx_q <= lastidx_d;
            beatcnt_q <= beatcnt_d;
            if (HREADY) begin
                didx_p1 <= GrantIdx;
                dvld_p1 <= ownerreq;
            end
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(Grant));
    a_state:  assert property (@(posedge clk) disable iff (reset)
                               GrantValid == (state_q == OWNED));
endmodule

// File: tb/tb_ahbarbiter.sv
// Bench for ahbarbiter: directed vector table, hand sequences, randomized run vs model.
module tb_ahbarbiter;
    localparam int N    = 3;
    localparam int MAXB = 4;
`ifdef AHBARB_LOCK_EN
    localparam bit LOCKMODE = 1'b1;
`else
    localparam bit LOCKMODE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] Req = '0;
    logic [N-1:0] Lock = '0;
    logic         HREADY = 1'b1;
    logic [N-1:0] Grant;
    logic [1:0]   GrantIdx;
    logic         GrantValid;
    logic [1:0]   DataIdx;
    logic         DataValid;

    int nvec = 0;
    int nfail = 0;

    int m_owner = -1;
    int m_last  = N - 1;
    int m_beats = 0;
    int m_didx  = 0;
    bit m_dvld  = 1'b0;

    ahbarbiter #(.N(N), .MAXBEATS(MAXB)) dut (
        .clk(clk), .reset(reset), .Req(Req), .Lock(Lock), .HREADY(HREADY),
        .Grant(Grant), .GrantIdx(GrantIdx), .GrantValid(GrantValid),
        .DataIdx(DataIdx), .DataValid(DataValid)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: owner as an int (-1 = none), rotation by modular scan.
    task automatic model_update();
        bit accepted, locked, others, limit, fire;
        int win, c;
        if (reset) begin
            m_owner = -1; m_last = N - 1; m_beats = 0; m_didx = 0; m_dvld = 1'b0;
            return;
        end
        if (!HREADY) return;
        accepted = (m_owner >= 0) && Req[m_owner];
        locked   = LOCKMODE && (m_owner >= 0) && Lock[m_owner];
        others   = 1'b0;
        for (int j = 0; j < N; j++) if (j != m_owner && Req[j]) others = 1'b1;
        limit = accepted && others && !locked && (m_beats >= MAXB - 1);
        fire  = ((m_owner < 0) && (Req != 0)) ||
                ((m_owner >= 0) && !Req[m_owner] && !locked) || limit;
        m_dvld = accepted;
        m_didx = (m_owner < 0) ? 0 : m_owner;
        if (fire) begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (win < 0 && Req[c] && !(limit && c == m_owner)) win = c;
            end
            m_owner = win;
            if (win >= 0) m_last = win;
            m_beats = 0;
        end else if (accepted) begin
            if (m_beats >= MAXB - 1 && !others) m_beats = 0;
            else if (m_beats < 2 * MAXB - 1) m_beats++;
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                        input logic hr);
        reset = r; Req = rq; Lock = lk; HREADY = hr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk_model(input int cyc);
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
        chk($sformatf("rnd%0d.grant", cyc), 32'(Grant), 32'(eg));
        chk($sformatf("rnd%0d.gidx", cyc), 32'(GrantIdx), (m_owner < 0) ? 0 : m_owner);
        chk($sformatf("rnd%0d.gvalid", cyc), 32'(GrantValid), 32'(m_owner >= 0));
        chk($sformatf("rnd%0d.didx", cyc), 32'(DataIdx), m_didx);
        chk($sformatf("rnd%0d.dvalid", cyc), 32'(DataValid), 32'(m_dvld));
    endtask

    task automatic chk_gd(input string nm, input logic [N-1:0] g, input int di, input logic dv);
        chk({nm, ".grant"}, 32'(Grant), 32'(g));
        chk({nm, ".didx"}, 32'(DataIdx), di);
        chk({nm, ".dvalid"}, 32'(DataValid), 32'(dv));
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         hr;
        logic [N-1:0] g;
        int           gi;
        logic         dv;
        int           di;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [N-1:0] rq, lk, eg;
        tbl[0]  = '{1'b1, 3'b000, 1'b1, 3'b000, 0, 1'b0, 0};
        tbl[1]  = '{1'b1, 3'b000, 1'b1, 3'b000, 0, 1'b0, 0};
        tbl[2]  = '{1'b0, 3'b010, 1'b1, 3'b010, 1, 1'b0, 0};
        tbl[3]  = '{1'b0, 3'b010, 1'b1, 3'b010, 1, 1'b1, 1};
        tbl[4]  = '{1'b0, 3'b010, 1'b0, 3'b010, 1, 1'b1, 1};
        tbl[5]  = '{1'b0, 3'b000, 1'b1, 3'b000, 0, 1'b0, 1};
        tbl[6]  = '{1'b0, 3'b000, 1'b1, 3'b000, 0, 1'b0, 0};
        tbl[7]  = '{1'b0, 3'b111, 1'b1, 3'b100, 2, 1'b0, 0};
        tbl[8]  = '{1'b0, 3'b011, 1'b1, 3'b001, 0, 1'b0, 2};
        tbl[9]  = '{1'b0, 3'b011, 1'b1, 3'b001, 0, 1'b1, 0};
        tbl[10] = '{1'b0, 3'b010, 1'b1, 3'b010, 1, 1'b0, 0};
        tbl[11] = '{1'b1, 3'b010, 1'b1, 3'b000, 0, 1'b0, 0};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].req, 3'b000, tbl[i].hr);
            chk($sformatf("tbl%0d.grant", i), 32'(Grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d.gidx", i), 32'(GrantIdx), tbl[i].gi);
            chk($sformatf("tbl%0d.gvalid", i), 32'(GrantValid), 32'(|tbl[i].g));
            chk($sformatf("tbl%0d.didx", i), 32'(DataIdx), tbl[i].di);
            chk($sformatf("tbl%0d.dvalid", i), 32'(DataValid), 32'(tbl[i].dv));
        end

        // Limit preemption: manager 0 streams, manager 2 joins; switch after 4th beat.
        step(1'b1, 3'b000, 3'b000, 1'b1);
        step(1'b0, 3'b001, 3'b000, 1'b1);
        chk_gd("lim.grant0", 3'b001, 0, 1'b0);
        step(1'b0, 3'b001, 3'b000, 1'b1);
        step(1'b0, 3'b101, 3'b000, 1'b1);
        step(1'b0, 3'b101, 3'b000, 1'b1);
        chk_gd("lim.beat3", 3'b001, 0, 1'b1);
        step(1'b0, 3'b101, 3'b000, 1'b1);
        chk_gd("lim.switch", 3'b100, 0, 1'b1);
        chk("lim.gidx", 32'(GrantIdx), 2);

        // HREADY stall with competitors: everything holds, arbitration on release.
        step(1'b0, 3'b101, 3'b000, 1'b1);
        chk_gd("stall.pre", 3'b100, 2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'b011, 3'b000, 1'b0);
            chk_gd($sformatf("stall%0d", i), 3'b100, 2, 1'b1);
        end
        step(1'b0, 3'b011, 3'b000, 1'b1);
        chk_gd("stall.release", 3'b001, 2, 1'b0);

        // Reset in the middle of a burst.
        step(1'b0, 3'b011, 3'b000, 1'b1);
        chk_gd("rstmid.pre", 3'b001, 0, 1'b1);
        step(1'b1, 3'b011, 3'b000, 1'b1);
        chk_gd("rstmid", 3'b000, 0, 1'b0);
        chk("rstmid.gvalid", 32'(GrantValid), 0);
        chk("rstmid.gidx", 32'(GrantIdx), 0);

        // Lock on manager 0 with manager 1 waiting.
        step(1'b0, 3'b011, 3'b001, 1'b1);
        chk("lock.grant0", 32'(Grant), 32'(3'b001));
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 3'b011, 3'b001, 1'b1);
            if (LOCKMODE) eg = 3'b001;
            else eg = (((k / MAXB) % 2) == 0) ? 3'b001 : 3'b010;
            chk($sformatf("lock.k%0d", k), 32'(Grant), 32'(eg));
        end
        step(1'b0, 3'b011, 3'b000, 1'b1);
        chk("lock.release", 32'(Grant), 32'(3'b010));

        // Randomized run against the reference model.
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 99) < 25) rq[b] = ~rq[b];
            lk = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            step(($urandom_range(0, 199) == 0), rq, lk, ($urandom_range(0, 3) != 0));
            chk_model(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/ahbarbiter.md
# ahbarbiter

Round-robin arbiter that shares the single AHB subordinate-side port among N managers in the multi-manager interconnect. It accepts per-manager transfer requests and produces a registered one-hot grant plus its binary index. The index is derived through the existing priorityencoder. It also tracks the data-phase owner so that the read-data and response muxes stay aligned with the pipelined AHB address/data phases. A beat counter bounds how long one manager can hold the bus while others are waiting.

## Interface
- `N`, 3: number of managers; N ≥ 2.
- `MAXBEATS`, 16: accepted address beats before a waiting requester forces rotation; power of two, ≥ 2.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `Req` in N: manager i has a non-IDLE HTRANS pending.
- `Lock` in N: manager i HMASTLOCK; used only when the lock feature is compiled in.
- `HREADY` in 1: bus ready; an address beat is accepted when high.
- `Grant` out N: one-hot address-phase owner, registered; all zero when there is no owner.
- `GrantIdx` out $clog2(N): binary index of `Grant`, from priorityencoder; 0 when there is no owner.
- `GrantValid` out 1: `|Grant`.
- `DataIdx` out $clog2(N): data-phase owner index.
- `DataValid` out 1: a data phase is in progress for `DataIdx`.

## Operation
- **States:** IDLE (no owner) and OWNED (`Grant` one-hot).
- **Registers:**
  - `Grant`
  - `LastIdx`: previous winner; reset value N-1, so manager 0 wins first.
  - `BeatCnt`: width $clog2(MAXBEATS)+1.
  - `DataIdx` and `DataValid`
- **Accepted beat:** HREADY=1 and Req[owner]=1. Each accepted beat increments `BeatCnt`.
- **Arbitration event.** Evaluated only when HREADY=1. Any one of these conditions triggers it:
  - state is IDLE and `|Req`;
  - owner's Req=0;
  - `BeatCnt`==MAXBEATS-1, the current beat is accepted, and some other Req[j]=1 (j≠owner). This is a limit preemption.
- **Winner selection:** the first set Req, scanning from (LastIdx+1) mod N upward with wrap-around.
  - On a limit preemption the current owner is excluded from the scan.
  - Otherwise the owner is eligible only after all others in scan order.
- **On arbitration with a winner:**
  - `Grant` ← onehot(winner)
  - `LastIdx` ← winner
  - `BeatCnt` ← 0
- **On arbitration with no winner:** `Grant` ← 0, go to IDLE; `LastIdx` is unchanged.
- **Limit reached with no other requester:** the owner keeps the grant and `BeatCnt` wraps to 0.
- **HREADY=0:** all registers hold, including `Grant`, `BeatCnt`, `DataIdx` and `DataValid`.
- **Data phase:** when HREADY=1, `DataIdx` ← `GrantIdx` and `DataValid` ← `GrantValid` & Req[owner].
- **Reset values:**
  - `Grant`=0 (state IDLE)
  - `GrantIdx`=0
  - `GrantValid`=0
  - `DataIdx`=0
  - `DataValid`=0
  - `BeatCnt`=0
  - `LastIdx`=N-1
- **Reset mid-burst:** outputs return to their reset values at the next edge, with no completion of the burst.

## Timing
- Grant latency is one cycle. Example: Req asserted in cycle t while IDLE with HREADY=1 gives `Grant` valid in cycle t+1.
- Handover is zero-bubble. When arbitration fires in cycle t, the new owner is granted in cycle t+1, and the old owner's last beat has its data phase in t+1 (`DataIdx` = old owner).
- `GrantIdx` is combinational from registered `Grant`, so it has no extra latency.
- `DataIdx` trails `GrantIdx` by exactly one HREADY-high cycle.
- Simultaneous requests resolve purely by round-robin order; there is no fixed priority.

## Configuration
- **`AHBARB_LOCK_EN` defined:**
  - While Lock[owner]=1, limit preemption is suppressed.
  - The owner retains `Grant` even with Req[owner]=0 (locked idle cycles).
  - Arbitration resumes on the first HREADY-high cycle with Lock[owner]=0.
  - `BeatCnt` still counts but does not trigger rotation.
- **Undefined:**
  - The `Lock` port exists but is ignored.
  - Locked sequences can be preempted after MAXBEATS beats.

## Test plan
- **Reset then single request:** reset=1 for 2 cycles, then Req=3'b010 with HREADY=1 → cycle+1 `Grant`=010, `GrantIdx`=1; cycle+2 `DataIdx`=1, `DataValid`=1.
- **Simultaneous requests from reset:** Req=3'b111 held, each owner dropping Req after 1 beat → grant order 0,1,2,0, each grant lasting exactly one cycle.
- **Limit preemption:** MAXBEATS=4, manager 0 streaming, manager 2 requests at beat 1 → `Grant` switches to 100 in the cycle after the 4th accepted beat of manager 0; `DataIdx`=0 in that cycle.
- **HREADY stall:** HREADY=0 for 5 cycles mid-transfer with a competing Req → `Grant`, `BeatCnt` and `DataIdx` unchanged; arbitration occurs only on the first HREADY=1 cycle.
- **Lock:** with `AHBARB_LOCK_EN`, Lock[0]=1 for 20 beats, MAXBEATS=4, Req[1]=1 → `Grant` stays 001 until Lock[0] falls, then moves to 010 next cycle. Without the macro → switch after beat 4.
- **Reset mid-burst and idle return:** reset during an OWNED burst → all outputs 0 next cycle. Separately, owner drops Req with no other requester → `Grant`=0 next cycle, `DataValid`=0 one cycle later.
